// File: rtl/icache_tag_arbiter.sv
// icache_tag_arbiter: shares the ICache tag port between the invalidate sweep, refill writes and IF1 lookups
module icache_tag_arbiter #(
  parameter int NUM_SETS  = 64,
  parameter int NUM_WAYS  = 4,
  parameter int SET_IDX_W = $clog2(NUM_SETS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_fetch_req,
  input  logic [SET_IDX_W-1:0] i_fetch_set,
  output logic                 o_fetch_avail,
  input  logic                 i_refill_req,
  input  logic [SET_IDX_W-1:0] i_refill_set,
  input  logic [NUM_WAYS-1:0]  i_refill_way,
  output logic                 o_refill_grant,
  input  logic                 i_inv_start,
  output logic                 o_inv_busy,
  output logic                 o_inv_done,
  output logic                 o_tag_en,
  output logic                 o_tag_we,
  output logic [SET_IDX_W-1:0] o_tag_set,
  output logic [NUM_WAYS-1:0]  o_tag_way_mask,
  output logic                 o_tag_wsel_refill
);
  typedef enum logic [1:0] {SWEEP, DONE, IDLE} st_t;
  st_t                 st, st_nxt;
  logic [SET_IDX_W-1:0] cnt, cnt_nxt;
  logic                 pend, pend_nxt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      st   <= SWEEP;
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      st   <= st_nxt;
      cnt  <= cnt_nxt;
      pend <= pend_nxt;
    end
  always_comb begin
    st_nxt            = st;
    cnt_nxt           = cnt;
    pend_nxt          = pend;
    o_fetch_avail     = 1'b0;
    o_refill_grant    = 1'b0;
    o_inv_busy        = 1'b0;
    o_inv_done        = 1'b0;
    o_tag_en          = 1'b0;
    o_tag_we          = 1'b0;
    o_tag_set         = '0;
    o_tag_way_mask    = '0;
    o_tag_wsel_refill = 1'b0;
    case (st)
      SWEEP: begin
        o_tag_en       = 1'b1;
        o_tag_we       = 1'b1;
        o_tag_set      = cnt;
        o_tag_way_mask = '1;
        o_inv_busy     = 1'b1;
        cnt_nxt        = cnt + 1'b1;
        pend_nxt       = pend | i_inv_start;
        st_nxt         = (cnt == SET_IDX_W'(NUM_SETS - 1)) ? DONE : SWEEP;
      end
      DONE: begin
        // a start seen here collapses with any pending one into a single extra sweep
        o_inv_done = 1'b1;
        st_nxt     = (pend | i_inv_start) ? SWEEP : IDLE;
        pend_nxt   = 1'b0;
      end
      IDLE: begin
        o_refill_grant    = i_refill_req;
        o_fetch_avail     = !i_refill_req;
        o_tag_en          = i_refill_req | i_fetch_req;
        o_tag_we          = i_refill_req;
        o_tag_wsel_refill = i_refill_req;
        o_tag_set         = i_refill_req ? i_refill_set : i_fetch_req ? i_fetch_set : '0;
        o_tag_way_mask    = i_refill_req ? i_refill_way : i_fetch_req ? '1 : '0;
        st_nxt            = i_inv_start ? SWEEP : IDLE;
        cnt_nxt           = '0;
      end
      default: begin
        st_nxt  = SWEEP;
        cnt_nxt = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_icache_tag_arbiter.sv
// tb_icache_tag_arbiter: directed checks of sweep, arbitration, pending invalidate and async reset
module tb_icache_tag_arbiter;
  logic       i_clk, i_rst_n;
  logic       i_fetch_req, i_refill_req, i_inv_start;
  logic [5:0] i_fetch_set, i_refill_set;
  logic [3:0] i_refill_way;
  logic       o_fetch_avail, o_refill_grant, o_inv_busy, o_inv_done;
  logic       o_tag_en, o_tag_we, o_tag_wsel_refill;
  logic [5:0] o_tag_set;
  logic [3:0] o_tag_way_mask;
  logic [16:0] obs;
  int errors = 0;
  int checks = 0;

  icache_tag_arbiter #(.NUM_SETS(64), .NUM_WAYS(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_fetch_req(i_fetch_req), .i_fetch_set(i_fetch_set), .o_fetch_avail(o_fetch_avail),
    .i_refill_req(i_refill_req), .i_refill_set(i_refill_set), .i_refill_way(i_refill_way),
    .o_refill_grant(o_refill_grant), .i_inv_start(i_inv_start), .o_inv_busy(o_inv_busy),
    .o_inv_done(o_inv_done), .o_tag_en(o_tag_en), .o_tag_we(o_tag_we), .o_tag_set(o_tag_set),
    .o_tag_way_mask(o_tag_way_mask), .o_tag_wsel_refill(o_tag_wsel_refill)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // {en, we, set, mask, wsel, busy, done, avail, grant}
  assign obs = {o_tag_en, o_tag_we, o_tag_set, o_tag_way_mask,
                o_tag_wsel_refill, o_inv_busy, o_inv_done, o_fetch_avail, o_refill_grant};

  function automatic logic [16:0] sw(int i);
    return {2'b11, 6'(i), 4'hf, 5'b01000};
  endfunction
  function automatic logic [16:0] refill_v(int s, int w);
    return {2'b11, 6'(s), 4'(w), 5'b10001};
  endfunction
  function automatic logic [16:0] fetch_v(int s);
    return {2'b10, 6'(s), 4'hf, 5'b00010};
  endfunction
  localparam logic [16:0] DONE_V = 17'b00_000000_0000_00100;
  localparam logic [16:0] IDLE_V = 17'b00_000000_0000_00010;

  task automatic test_reset;
    logic [16:0] exp;
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    checks++;
    if (obs !== sw(0)) begin errors++; $display("FAIL reset_hold obs=%h exp=%h", obs, sw(0)); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    for (int c = 0; c <= 65; c++) begin
      if (c > 0) begin @(negedge i_clk); #1; end
      exp = c < 64 ? sw(c) : c == 64 ? DONE_V : IDLE_V;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_sweep c=%0d obs=%h exp=%h", c, obs, exp); end
    end
  endtask

  task automatic test_arbitration;
    @(negedge i_clk);
    i_refill_req = 1'b1; i_refill_set = 6'd5; i_refill_way = 4'b0100;
    i_fetch_req = 1'b1; i_fetch_set = 6'd9;
    #1;
    checks++;
    if (obs !== refill_v(5, 4)) begin errors++; $display("FAIL arb_refill obs=%h exp=%h", obs, refill_v(5, 4)); end
    @(negedge i_clk);
    i_refill_req = 1'b0;
    #1;
    checks++;
    if (obs !== fetch_v(9)) begin errors++; $display("FAIL arb_fetch obs=%h exp=%h", obs, fetch_v(9)); end
    @(negedge i_clk);
    i_fetch_req = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_V) begin errors++; $display("FAIL arb_idle obs=%h exp=%h", obs, IDLE_V); end
  endtask

  task automatic test_pending_inv;
    logic [16:0] exp;
    int pulses = 0;
    @(negedge i_clk);
    i_inv_start = 1'b1;
    #1;
    checks++;
    if (obs !== IDLE_V) begin errors++; $display("FAIL inv_idle_cycle obs=%h exp=%h", obs, IDLE_V); end
    for (int c = 0; c <= 131; c++) begin
      @(negedge i_clk);
      i_inv_start = (c == 10);
      #1;
      exp = c < 64 ? sw(c) : c == 64 ? DONE_V : c < 129 ? sw(c - 65) : c == 129 ? DONE_V : IDLE_V;
      pulses += int'(o_inv_done);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL pend_sweep c=%0d obs=%h exp=%h", c, obs, exp); end
    end
    i_inv_start = 1'b0;
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL pend_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_async_reset;
    logic [16:0] exp;
    @(negedge i_clk);
    i_inv_start = 1'b1;
    @(negedge i_clk);
    i_inv_start = 1'b0;
    #1;
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) begin @(negedge i_clk); #1; end
      checks++;
      if (obs !== sw(c)) begin errors++; $display("FAIL pre_rst c=%0d obs=%h exp=%h", c, obs, sw(c)); end
    end
    #1 i_rst_n = 1'b0;
    #2;
    checks++;
    if (obs !== sw(0)) begin errors++; $display("FAIL async_rst obs=%h exp=%h", obs, sw(0)); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    for (int c = 0; c <= 65; c++) begin
      if (c > 0) begin @(negedge i_clk); #1; end
      exp = c < 64 ? sw(c) : c == 64 ? DONE_V : IDLE_V;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL post_rst c=%0d obs=%h exp=%h", c, obs, exp); end
    end
  endtask

  task automatic test_refill_held;
    logic [16:0] exp;
    @(negedge i_clk);
    i_inv_start = 1'b1;
    for (int c = 0; c <= 65; c++) begin
      @(negedge i_clk);
      i_inv_start = 1'b0;
      if (c == 20) begin
        i_refill_req = 1'b1; i_refill_set = 6'd33; i_refill_way = 4'b1000;
      end
      #1;
      exp = c < 64 ? sw(c) : c == 64 ? DONE_V : refill_v(33, 8);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL refill_held c=%0d obs=%h exp=%h", c, obs, exp); end
    end
    @(negedge i_clk);
    i_refill_req = 1'b0;
    #1;
    checks++;
    if (obs !== IDLE_V) begin errors++; $display("FAIL refill_release obs=%h exp=%h", obs, IDLE_V); end
  endtask

  task automatic test_inv_with_refill;
    logic [16:0] exp;
    @(negedge i_clk);
    i_inv_start = 1'b1; i_refill_req = 1'b1; i_refill_set = 6'd7; i_refill_way = 4'b0001;
    #1;
    checks++;
    if (obs !== refill_v(7, 1)) begin errors++; $display("FAIL inv_refill obs=%h exp=%h", obs, refill_v(7, 1)); end
    for (int c = 0; c <= 65; c++) begin
      @(negedge i_clk);
      i_inv_start = 1'b0; i_refill_req = 1'b0;
      #1;
      exp = c < 64 ? sw(c) : c == 64 ? DONE_V : IDLE_V;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL inv_refill_sweep c=%0d obs=%h exp=%h", c, obs, exp); end
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_fetch_req = 1'b0; i_refill_req = 1'b0; i_inv_start = 1'b0;
    i_fetch_set = '0; i_refill_set = '0; i_refill_way = '0;
    test_reset;
    test_arbitration;
    test_pending_inv;
    test_async_reset;
    test_refill_held;
    test_inv_with_refill;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
